key_step_counter: RTL and testbench
===================================

Name: key_step_counter

Overview:
- Upstream feeder for the 4-bit binary-to-decimal display stage.
- Takes two raw active-low DE-series pushbuttons (up, down), synchronises and debounces them, and steps a 4-bit modulo-16 count.
- Also supports a synchronous load from the slide switches.
- to_COUNT drives the display stage's 4-bit input in place of the switches, so a user can walk through 0..15 and watch the decimal conversion.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required to accept a press or release (10 ms at 50 MHz); legal range 2..2^20-1.
- REPEAT_CYCLES, 12500000, auto-repeat interval while a key is held (250 ms at 50 MHz); used only with the optional feature.

Ports:
- fr_CLK, input, 1, system clock (50 MHz board clock).
- fr_RST_N, input, 1, asynchronous active-low reset.
- fr_KEY_UP, input, 1, raw pushbutton, active-low, asynchronous to fr_CLK.
- fr_KEY_DN, input, 1, raw pushbutton, active-low, asynchronous to fr_CLK.
- fr_LOAD, input, 1, synchronous level; when high, the count is loaded from fr_SW.
- fr_SW, input, 4, load value.
- to_COUNT, output, 4, current count (registered); feeds the binary-to-decimal stage.
- to_STEP, output, 1, one-cycle pulse on every count change caused by a key.
- to_LEDR, output, 10, [3:0]=to_COUNT, [4]=up key debounced-held, [5]=down key debounced-held, [9:6]=0.

Behaviour:
- Reset: the only reset is fr_RST_N, asynchronous assert, synchronous deassert handled at board level.
  - Reset value of to_COUNT is 0, to_STEP is 0, to_LEDR is 0.
  - All FSMs reset to S_IDLE; all counters reset to 0; synchroniser flops reset to 1 (released).
  - Reset mid-debounce or mid-hold discards all progress. A key still held after reset release must first complete a full press debounce before it is counted.
- Synchroniser: 2-flop per key. Inverted synchroniser output = pressed (p).
- Debounce FSM, one per key, with a shared-width counter cnt:
  - S_IDLE: if p, cnt<=1 and go to S_PRESS_WAIT.
  - S_PRESS_WAIT:
    - if !p, go to S_IDLE (glitch rejected, no step).
    - else if cnt==DEBOUNCE_CYCLES-1, go to S_HELD and emit a press event (one cycle).
    - else cnt++.
  - S_HELD: if !p, cnt<=1 and go to S_REL_WAIT.
  - S_REL_WAIT:
    - if p, go to S_HELD (bounce, no new event).
    - else if cnt==DEBOUNCE_CYCLES-1, go to S_IDLE.
    - else cnt++.
- Latency: the raw key is first sampled low at edge N. The synchroniser output is low after edge N+1. The press event is registered and to_COUNT/to_STEP update at edge N+1+DEBOUNCE_CYCLES.
- Count update, evaluated every cycle in priority order:
  1. fr_LOAD=1: to_COUNT<=fr_SW, to_STEP=0. Key events that cycle are dropped.
  2. up and down events in the same cycle: no change, to_STEP=0.
  3. up event: to_COUNT<=to_COUNT+1 mod 16 (15 wraps to 0), to_STEP=1.
  4. down event: to_COUNT<=to_COUNT-1 mod 16 (0 wraps to 15), to_STEP=1.
- Holding a key never produces more than one event unless AUTO_REPEAT_EN is defined.
- No combinational path from any input to any output.

Optional Feature:
- Macro: KEY_AUTO_REPEAT_EN.
- Defined:
  - Each FSM has a repeat counter, cleared on entry to S_HELD.
  - While in S_HELD with p, an extra event fires every REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES cycles after the press event.
  - Repeat events obey the same priority and wrap rules as press events.
  - The counter clears on leaving S_HELD. Returning from S_REL_WAIT restarts the full interval.
- Undefined: the repeat logic is absent; exactly one event per debounced press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Reset then clean press: fr_KEY_UP low from edge 10, held 20 cycles -> to_COUNT 0->1 and to_STEP=1 only at edge 15; no further change on release.
- Bounce rejection: fr_KEY_DN low for 2 cycles, high 1, low 2, then high -> to_COUNT unchanged, to_STEP never asserted.
- Wrap and release bounce: load 15 via fr_LOAD, fr_SW=4'hF; debounced up press -> to_COUNT=0. Release with 1-cycle re-press glitch inside the release window -> no extra step. Debounced down press -> to_COUNT=15.
- Simultaneous events and load priority:
  - Both keys pressed on the same edge with count=7 -> stays 7, to_STEP=0.
  - fr_LOAD=1, fr_SW=4'h9 asserted the same cycle as an up event -> to_COUNT=9.
- Reset mid-hold: up held past debounce (count=1), fr_RST_N pulsed low while key still held -> to_COUNT=0. No step until a full 4-cycle debounce completes after reset release, then count=1.
- With KEY_AUTO_REPEAT_EN: up held 30 cycles after press event at count 0 -> count 1 at event, then 2, 3, 4 at +8, +16, +24 cycles. Without the macro -> count stays 1.

Source files
------------

// File: rtl/key_step_counter_if.sv
// key_step_counter_if
//   Groups the pushbutton/switch inputs and the count/LED outputs of
//   key_step_counter. The master drives the raw keys, load level and switch
//   value. The slave (the counter) drives the count, the step pulse and the LEDs.
//   fr_KEY_UP, fr_KEY_DN : raw active-low pushbuttons (asynchronous)
//   fr_LOAD, fr_SW[3:0]  : synchronous load strobe and load value
//   to_COUNT[3:0]        : registered modulo-16 count
//   to_STEP              : one-cycle pulse on every key-caused count change
//   to_LEDR[9:0]         : {4'b0, down held, up held, count}
interface key_step_counter_if;
  logic       fr_KEY_UP;
  logic       fr_KEY_DN;
  logic       fr_LOAD;
  logic [3:0] fr_SW;
  logic [3:0] to_COUNT;
  logic       to_STEP;
  logic [9:0] to_LEDR;

  modport master (
    output fr_KEY_UP, fr_KEY_DN, fr_LOAD, fr_SW,
    input  to_COUNT, to_STEP, to_LEDR
  );

  modport slave (
    input  fr_KEY_UP, fr_KEY_DN, fr_LOAD, fr_SW,
    output to_COUNT, to_STEP, to_LEDR
  );
endinterface

// File: rtl/key_step_counter.sv
// key_step_counter
//   Synchronises and debounces two raw active-low pushbuttons (up/down). It steps
//   a 4-bit modulo-16 count that feeds the binary-to-decimal display stage. The
//   count can also be loaded synchronously from the slide switches.
// Ports:
//   fr_CLK   : system clock
//   fr_RST_N : asynchronous active-low reset
//   bus      : key_step_counter_if.slave (keys, load, switches, count, step, LEDs)
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronised cycles needed to accept a press/release
//   REPEAT_CYCLES   : auto-repeat interval while a key stays held
// Optional feature:
//   Defining KEY_AUTO_REPEAT_EN adds one extra event every REPEAT_CYCLES
//   cycles while a key stays debounced-held.
module key_step_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic               fr_CLK,
  input  logic               fr_RST_N,
  key_step_counter_if.slave  bus
);

  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (2**CNT_W) - 1 || REPEAT_CYCLES < 1)
  begin : g_bad_param
    $error("key_step_counter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_REL_WAIT
  } state_t;

  // Index 0 = up key, index 1 = down key
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  state_t           r_state [2];
  logic [CNT_W-1:0] r_cnt   [2];
  logic [1:0]       r_held;
  logic [3:0]       r_count;
  logic             r_step;

  logic [1:0]       w_p;
  logic [1:0]       w_evt;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rep [2];
`endif

  // Flops reset to 1 so a key held through reset looks released afterwards.
  always_ff @(posedge fr_CLK or negedge fr_RST_N) begin
    if (!fr_RST_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {bus.fr_KEY_DN, bus.fr_KEY_UP};
      r_sync2 <= r_sync1;
    end
  end

  // Events are decoded from registered state, so the count changes on the same
  // edge as the FSM enters S_HELD. This gives a press-to-count latency of
  // exactly DEBOUNCE_CYCLES after the synchroniser output changes.
  always_comb begin
    w_p   = ~r_sync2;
    w_evt = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (r_state[k] == S_PRESS_WAIT && w_p[k] && r_cnt[k] == DB_LAST)
        w_evt[k] = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
      if (r_state[k] == S_HELD && w_p[k] && r_rep[k] == RPT_LAST)
        w_evt[k] = 1'b1;
`endif
    end
  end

  always_ff @(posedge fr_CLK or negedge fr_RST_N) begin
    if (!fr_RST_N) begin
      for (int unsigned k = 0; k < 2; k++) begin
        r_state[k] <= S_IDLE;
        r_cnt[k]   <= '0;
`ifdef KEY_AUTO_REPEAT_EN
        r_rep[k]   <= '0;
`endif
      end
      r_held <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        case (r_state[k])
          S_IDLE: begin
            if (w_p[k]) begin
              r_cnt[k]   <= CNT_ONE;
              r_state[k] <= S_PRESS_WAIT;
            end
          end
          S_PRESS_WAIT: begin
            if (!w_p[k]) begin
              r_state[k] <= S_IDLE;
            end else if (r_cnt[k] == DB_LAST) begin
              r_state[k] <= S_HELD;
              r_held[k]  <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
              r_rep[k]   <= '0;
`endif
            end else begin
              r_cnt[k] <= r_cnt[k] + 1'b1;
            end
          end
          S_HELD: begin
            if (!w_p[k]) begin
              r_cnt[k]   <= CNT_ONE;
              r_state[k] <= S_REL_WAIT;
`ifdef KEY_AUTO_REPEAT_EN
              r_rep[k]   <= '0;
`endif
            end
`ifdef KEY_AUTO_REPEAT_EN
            else if (r_rep[k] == RPT_LAST) begin
              r_rep[k] <= '0;
            end else begin
              r_rep[k] <= r_rep[k] + 1'b1;
            end
`endif
          end
          S_REL_WAIT: begin
            if (w_p[k]) begin
              r_state[k] <= S_HELD;
`ifdef KEY_AUTO_REPEAT_EN
              r_rep[k]   <= '0;
`endif
            end else if (r_cnt[k] == DB_LAST) begin
              r_state[k] <= S_IDLE;
              r_held[k]  <= 1'b0;
            end else begin
              r_cnt[k] <= r_cnt[k] + 1'b1;
            end
          end
          default: r_state[k] <= S_IDLE;
        endcase
      end
    end
  end

  // Load beats keys; opposing events cancel.
  always_ff @(posedge fr_CLK or negedge fr_RST_N) begin
    if (!fr_RST_N) begin
      r_count <= '0;
      r_step  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (bus.fr_LOAD) begin
        r_count <= bus.fr_SW;
      end else if (w_evt == 2'b11) begin
        r_count <= r_count;
      end else if (w_evt[0]) begin
        r_count <= r_count + 4'd1;
        r_step  <= 1'b1;
      end else if (w_evt[1]) begin
        r_count <= r_count - 4'd1;
        r_step  <= 1'b1;
      end
    end
  end

  assign bus.to_COUNT = r_count;
  assign bus.to_STEP  = r_step;
  assign bus.to_LEDR  = {4'b0000, r_held[1], r_held[0], r_count};

endmodule

// File: tb/tb_key_step_counter.sv
module tb_key_step_counter;
  localparam int DB = 4;
  localparam int RP = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  key_step_counter_if bus ();

  key_step_counter #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .fr_CLK   (clk),
    .fr_RST_N (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [3:0] count;
    logic       step;
    int         at;    // expected clock edge index, -1 = any
    string      name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic s, input int at, input string name);
    exp_t e;
    e.count = c;
    e.step  = s;
    e.at    = at;
    e.name  = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any step pulse or count change is a DUT output to be scored.
  logic [3:0] prev = 4'd0;
  exp_t       me;
  always @(negedge clk) begin
    if (bus.to_STEP === 1'b1 || bus.to_COUNT !== prev) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: count=%0d step=%0b at edge %0d, nothing expected",
                 bus.to_COUNT, bus.to_STEP, cyc);
      end else begin
        me = sb.pop_front();
        check({me.name, "_count"}, 32'(bus.to_COUNT), 32'(me.count));
        check({me.name, "_step"},  32'(bus.to_STEP),  32'(me.step));
        if (me.at >= 0) check({me.name, "_edge"}, cyc, me.at);
      end
    end
    prev = bus.to_COUNT;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  int c;

  initial begin
    bus.fr_KEY_UP = 1'b1;
    bus.fr_KEY_DN = 1'b1;
    bus.fr_LOAD   = 1'b0;
    bus.fr_SW     = 4'h0;
    #1 rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    check("reset_count", 32'(bus.to_COUNT), 32'h0);
    check("reset_step",  32'(bus.to_STEP),  32'h0);
    check("reset_ledr",  32'(bus.to_LEDR),  32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(5);

    // Clean press held 20 cycles
    c = cyc;
    bus.fr_KEY_UP = 1'b0;
    push(4'd1, 1'b1, c + 6, "clean_press");
`ifdef KEY_AUTO_REPEAT_EN
    push(4'd2, 1'b1, c + 14, "clean_rep1");
    push(4'd3, 1'b1, c + 22, "clean_rep2");
`endif
    tick(10);
    check("held_ledr", 32'(bus.to_LEDR), 32'h011);
    tick(10);
    bus.fr_KEY_UP = 1'b1;
    tick(12);
`ifdef KEY_AUTO_REPEAT_EN
    check("released_ledr", 32'(bus.to_LEDR), 32'h003);
`else
    check("released_ledr", 32'(bus.to_LEDR), 32'h001);
`endif

    // Bounce rejection on down key
    bus.fr_KEY_DN = 1'b0; tick(2);
    bus.fr_KEY_DN = 1'b1; tick(1);
    bus.fr_KEY_DN = 1'b0; tick(2);
    bus.fr_KEY_DN = 1'b1; tick(12);
`ifdef KEY_AUTO_REPEAT_EN
    check("bounce_ledr", 32'(bus.to_LEDR), 32'h003);
`else
    check("bounce_ledr", 32'(bus.to_LEDR), 32'h001);
`endif

    // Load 15, up wraps to 0, release glitch, down wraps to 15
    c = cyc;
    bus.fr_LOAD = 1'b1; bus.fr_SW = 4'hF;
    push(4'd15, 1'b0, c + 1, "load15");
    tick(1);
    bus.fr_LOAD = 1'b0;
    tick(2);
    c = cyc;
    bus.fr_KEY_UP = 1'b0;
    push(4'd0, 1'b1, c + 6, "wrap_up");
    tick(8);
    bus.fr_KEY_UP = 1'b1; tick(3);
    bus.fr_KEY_UP = 1'b0; tick(1);
    bus.fr_KEY_UP = 1'b1; tick(12);
    check("glitch_ledr", 32'(bus.to_LEDR), 32'h000);
    c = cyc;
    bus.fr_KEY_DN = 1'b0;
    push(4'd15, 1'b1, c + 6, "wrap_dn");
    tick(8);
    bus.fr_KEY_DN = 1'b1;
    tick(12);

    // Simultaneous presses at count 7
    c = cyc;
    bus.fr_LOAD = 1'b1; bus.fr_SW = 4'h7;
    push(4'd7, 1'b0, c + 1, "load7");
    tick(1);
    bus.fr_LOAD = 1'b0;
    tick(2);
    bus.fr_KEY_UP = 1'b0;
    bus.fr_KEY_DN = 1'b0;
    tick(8);
    check("both_held_ledr", 32'(bus.to_LEDR), 32'h037);
    bus.fr_KEY_UP = 1'b1;
    bus.fr_KEY_DN = 1'b1;
    tick(12);

    // Load coincident with an up event
    c = cyc;
    bus.fr_KEY_UP = 1'b0;
    tick(5);
    bus.fr_LOAD = 1'b1; bus.fr_SW = 4'h9;
    push(4'd9, 1'b0, c + 6, "load_prio");
    tick(1);
    bus.fr_LOAD = 1'b0;
    tick(2);
    bus.fr_KEY_UP = 1'b1;
    tick(12);

    // Reset mid-hold
    c = cyc;
    bus.fr_LOAD = 1'b1; bus.fr_SW = 4'h0;
    push(4'd0, 1'b0, c + 1, "load0_a");
    tick(1);
    bus.fr_LOAD = 1'b0;
    tick(2);
    c = cyc;
    bus.fr_KEY_UP = 1'b0;
    push(4'd1, 1'b1, c + 6, "pre_reset_press");
    tick(10);
    rst_n = 1'b0;
    push(4'd0, 1'b0, -1, "mid_hold_reset");
    tick(2);
    check("in_reset_ledr", 32'(bus.to_LEDR), 32'h000);
    rst_n = 1'b1;
    c = cyc;
    push(4'd1, 1'b1, c + 6, "post_reset_press");
    tick(8);
    check("post_reset_ledr", 32'(bus.to_LEDR), 32'h011);
    bus.fr_KEY_UP = 1'b1;
    tick(12);

    // Long hold (auto-repeat when enabled)
    c = cyc;
    bus.fr_LOAD = 1'b1; bus.fr_SW = 4'h0;
    push(4'd0, 1'b0, c + 1, "load0_b");
    tick(1);
    bus.fr_LOAD = 1'b0;
    tick(2);
    c = cyc;
    bus.fr_KEY_UP = 1'b0;
    push(4'd1, 1'b1, c + 6, "hold_press");
`ifdef KEY_AUTO_REPEAT_EN
    push(4'd2, 1'b1, c + 14, "hold_rep1");
    push(4'd3, 1'b1, c + 22, "hold_rep2");
    push(4'd4, 1'b1, c + 30, "hold_rep3");
`endif
    tick(32);
    bus.fr_KEY_UP = 1'b1;
    tick(12);
`ifdef KEY_AUTO_REPEAT_EN
    check("hold_end_ledr", 32'(bus.to_LEDR), 32'h004);
`else
    check("hold_end_ledr", 32'(bus.to_LEDR), 32'h001);
`endif

    tick(5);
    check("scoreboard_drain", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
